// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: PC, imem address, IF/ID register
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned PC_STEP   = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en_i,
  input  logic        stall_if_i,
  input  logic        redirect_en_i,
  input  logic [31:0] redirect_pc_i,
  input  logic [31:0] read_instr_imem_ram_i,
  output logic [31:0] addr_imem_ram_o,
  output logic [31:0] pc_if_o,
  output logic [31:0] instr_if_o,
  output logic        valid_if_o,
  output logic        misalign_o,
  output logic [31:0] fetch_count_o
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  logic [31:0] pc_q;

  // imem reads combinationally, so the word at pc_q is captured this same cycle
  assign addr_imem_ram_o = pc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      pc_if_o       <= 32'h0000_0000;
      instr_if_o    <= NOP_INSTR;
      valid_if_o    <= 1'b0;
      misalign_o    <= 1'b0;
      fetch_count_o <= 32'h0000_0000;
    end else if (redirect_en_i) begin
      // Flush wins over stall: the stalled consumer simply sees a bubble
      pc_q       <= {redirect_pc_i[31:2], 2'b00};
      instr_if_o <= NOP_INSTR;
      valid_if_o <= 1'b0;
      misalign_o <= |redirect_pc_i[1:0];
    end else begin
      misalign_o <= 1'b0;
      if (!stall_if_i) begin
        if (!fetch_en_i) begin
          instr_if_o <= NOP_INSTR;
          valid_if_o <= 1'b0;
        end else begin
          pc_if_o       <= pc_q;
          instr_if_o    <= read_instr_imem_ram_i;
          valid_if_o    <= 1'b1;
          pc_q          <= pc_q + STEP;
          fetch_count_o <= fetch_count_o + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed plus randomized checks of instr_fetch against a reference model
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_en = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] rdata;
  logic [31:0] addr;
  logic [31:0] pc_if;
  logic [31:0] instr_if;
  logic        valid_if;
  logic        misalign;
  logic [31:0] fetch_count;

  int total = 0;
  int bad = 0;
  bit check_en = 1'b0;

  // reference state
  logic [31:0] m_pc, m_pc_if, m_instr, m_cnt;
  logic        m_valid, m_mis;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return 32'hA000_0000 + (a >> 2);
  endfunction

  assign rdata = imem_word(addr);

  instr_fetch dut (
    .clk                   (clk),
    .reset                 (reset),
    .fetch_en_i            (fetch_en),
    .stall_if_i            (stall),
    .redirect_en_i         (redirect_en),
    .redirect_pc_i         (redirect_pc),
    .read_instr_imem_ram_i (rdata),
    .addr_imem_ram_o       (addr),
    .pc_if_o               (pc_if),
    .instr_if_o            (instr_if),
    .valid_if_o            (valid_if),
    .misalign_o            (misalign),
    .fetch_count_o         (fetch_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: per-cycle priority reset > redirect > stall > fetch disabled > fetch
  always @(posedge clk) begin
    if (reset) begin
      m_pc = 32'h0; m_pc_if = 32'h0; m_instr = 32'h0;
      m_valid = 1'b0; m_mis = 1'b0; m_cnt = 32'h0;
    end else if (redirect_en) begin
      m_pc = redirect_pc & ~32'h3;
      m_valid = 1'b0; m_instr = 32'h0;
      m_mis = (redirect_pc % 4) != 0;
    end else begin
      m_mis = 1'b0;
      if (stall) begin
      end else if (!fetch_en) begin
        m_valid = 1'b0; m_instr = 32'h0;
      end else begin
        m_pc_if = m_pc;
        m_instr = imem_word(m_pc);
        m_valid = 1'b1;
        m_pc = m_pc + 32'd4;
        m_cnt = m_cnt + 32'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("addr",     addr,        m_pc);
      chk("pc_if",    pc_if,       m_pc_if);
      chk("instr_if", instr_if,    m_instr);
      chk("valid_if", {31'h0, valid_if}, {31'h0, m_valid});
      chk("misalign", {31'h0, misalign}, {31'h0, m_mis});
      chk("count",    fetch_count, m_cnt);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic f, input logic s, input logic r, input logic [31:0] rp);
    fetch_en = f; stall = s; redirect_en = r; redirect_pc = rp;
  endtask

  initial begin
    set_in(1, 0, 0, 0);
    reset = 1'b1;
    step();
    step();
    check_en = 1'b1;
    chk("rst_addr", addr, 32'h0);
    chk("rst_valid", {31'h0, valid_if}, 32'h0);
    chk("rst_count", fetch_count, 32'h0);
    chk("rst_instr", instr_if, 32'h0);
    reset = 1'b0;

    step();
    chk("f1_pc_if", pc_if, 32'h0);
    chk("f1_instr", instr_if, 32'hA000_0000);
    chk("f1_addr", addr, 32'h4);
    step();
    chk("f2_addr", addr, 32'h8);

    set_in(1, 1, 0, 0);
    repeat (3) step();
    chk("stall_addr", addr, 32'h8);
    chk("stall_pc_if", pc_if, 32'h4);
    chk("stall_instr", instr_if, 32'hA000_0001);
    chk("stall_count", fetch_count, 32'd2);

    set_in(1, 0, 0, 0);
    step();
    chk("rel_pc_if", pc_if, 32'h8);
    chk("rel_instr", instr_if, 32'hA000_0002);
    step();
    step();
    chk("five_count", fetch_count, 32'd5);

    set_in(1, 1, 1, 32'h0000_0040);
    step();
    chk("rd40_addr", addr, 32'h40);
    chk("rd40_valid", {31'h0, valid_if}, 32'h0);
    chk("rd40_instr", instr_if, 32'h0);
    chk("rd40_mis", {31'h0, misalign}, 32'h0);
    set_in(1, 0, 0, 0);
    step();
    chk("rd40_pc_if", pc_if, 32'h40);
    chk("rd40_valid2", {31'h0, valid_if}, 32'h1);
    chk("rd40_instr2", instr_if, 32'hA000_0010);

    set_in(1, 0, 1, 32'h0000_0046);
    step();
    chk("rd46_addr", addr, 32'h44);
    chk("rd46_mis", {31'h0, misalign}, 32'h1);
    set_in(1, 0, 0, 0);
    step();
    chk("rd46_mis_off", {31'h0, misalign}, 32'h0);

    set_in(1, 0, 1, 32'hFFFF_FFF8);
    step();
    chk("wrap_a0", addr, 32'hFFFF_FFF8);
    set_in(1, 0, 0, 0);
    step();
    chk("wrap_a1", addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_a2", addr, 32'h0000_0000);
    chk("wrap_pc_if", pc_if, 32'hFFFF_FFFC);
    step();
    chk("wrap_a3", addr, 32'h0000_0004);

    set_in(1, 1, 1, 32'h0000_0123);
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_in(0, 0, 0, 0);
    chk("rr_addr", addr, 32'h0);
    chk("rr_valid", {31'h0, valid_if}, 32'h0);
    chk("rr_count", fetch_count, 32'h0);
    chk("rr_mis", {31'h0, misalign}, 32'h0);
    step();
    step();
    chk("dis_addr", addr, 32'h0);
    chk("dis_valid", {31'h0, valid_if}, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 199) == 0);
      fetch_en    = ($urandom_range(0, 9) < 8);
      stall       = ($urandom_range(0, 9) < 2);
      redirect_en = ($urandom_range(0, 99) < 8);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
